// File: rtl/intersection_pkg.sv
// intersection_pkg: shared definitions for the multi-road intersection controller.
//   op_e           event/operation encodings driven on the op port
//   count_width()  bits needed to hold a queue occupancy of 0..depth
//   clamp_green()  saturate a proposed green length into [lo, hi]
package intersection_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_REM  = 2'b01,
    OP_DISP = 2'b10,
    OP_IDLE = 2'b11
  } op_e;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic logic [6:0] clamp_green(input int t, input int lo, input int hi);
    if (t < lo) return 7'(lo);
    if (t > hi) return 7'(hi);
    return 7'(t);
  endfunction

endpackage

// File: rtl/plate_fifo.sv
// plate_fifo: per-road FIFO of plate numbers.
//   push/pop   requests; a push when full or a pop when empty is ignored
//   din/dout   plate in / plate at FIFO head
//   full/empty occupancy flags
//   count      current occupancy; count_nxt is the occupancy after this edge
module plate_fifo
  import intersection_pkg::*;
#(
  parameter  int PLATE_W     = 5,
  parameter  int QUEUE_DEPTH = 8,
  localparam int CW          = count_width(QUEUE_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [PLATE_W-1:0] din,
  output logic [PLATE_W-1:0] dout,
  output logic               full,
  output logic               empty,
  output logic [CW-1:0]      count,
  output logic [CW-1:0]      count_nxt
);

  localparam int PW = $clog2(QUEUE_DEPTH);

  logic [PLATE_W-1:0] mem_q [QUEUE_DEPTH];
  logic [PLATE_W-1:0] mem_d [QUEUE_DEPTH];
  logic [PW-1:0]      wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               push_ok, pop_ok;

  assign full      = (cnt_q == CW'(QUEUE_DEPTH));
  assign empty     = (cnt_q == '0);
  assign dout      = mem_q[rd_q];
  assign count     = cnt_q;
  assign count_nxt = cnt_d;

  // Pointers wrap naturally because the depth is a power of two.
  always_comb begin
    push_ok = push & ~full;
    pop_ok  = pop & ~empty;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (push_ok) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + 1'b1;
    end
    if (pop_ok) rd_d = rd_q + 1'b1;
    cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multi_road_intersection.sv
// multi_road_intersection: round-robin green for NUM_ROADS approaches, one clk = 1 s.
// Each road has a plate queue; its next green length adapts to its queue occupancy
// at the end of its green (+STEP when busy, -STEP when quiet, clamped).
//   op/road_sel/plateIn/action  event request (rising edge of action = one event)
//   green            one-hot current green road
//   remainingTime    seconds left in current green (never 0)
//   numOfCars        per-road counts packed, road 0 in LSBs
//   overflow         one-cycle pulse when an add hits a full queue
//   blackListDisplay blacklist viewer, stepped each edge while op is display
// Build option: define BLACKLIST_EN to pop-and-record removes from a red road;
// otherwise such removes are ignored and blackListDisplay is tied to 0.
module multi_road_intersection
  import intersection_pkg::*;
#(
  parameter  int NUM_ROADS   = 4,
  parameter  int QUEUE_DEPTH = 8,
  parameter  int PLATE_W     = 5,
  parameter  int GREEN_INIT  = 40,
  parameter  int GREEN_MIN   = 20,
  parameter  int GREEN_MAX   = 80,
  parameter  int GREEN_STEP  = 5,
  parameter  int HI_THRESH   = 6,
  parameter  int LO_THRESH   = 2,
  parameter  int BL_DEPTH    = 8,
  localparam int RW          = $clog2(NUM_ROADS),
  localparam int CW          = count_width(QUEUE_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              op,
  input  logic [RW-1:0]           road_sel,
  input  logic [PLATE_W-1:0]      plateIn,
  input  logic                    action,
  output logic [NUM_ROADS-1:0]    green,
  output logic [6:0]              remainingTime,
  output logic [NUM_ROADS*CW-1:0] numOfCars,
  output logic                    overflow,
  output logic [PLATE_W-1:0]      blackListDisplay
);

  op_e                             op_i;
  logic                            action_q, ev, sel_ok, is_green_sel;
  logic [RW-1:0]                   cur_q, cur_d, nxt;
  logic [NUM_ROADS-1:0]            green_q, green_d;
  logic [6:0]                      rem_q, rem_d;
  logic [6:0]                      gtime_q [NUM_ROADS];
  logic [6:0]                      gtime_d [NUM_ROADS];
  logic                            overflow_q, overflow_d;
  logic [NUM_ROADS-1:0]            push_v, pop_v, full_v, empty_v;
  logic [NUM_ROADS-1:0][PLATE_W-1:0] head;
  logic [NUM_ROADS-1:0][CW-1:0]    cnt, cnt_nxt;
  logic [CW-1:0]                   cnt_lv;
`ifdef BLACKLIST_EN
  logic                            bl_push;
`endif

  assign op_i          = op_e'(op);
  assign ev            = action & ~action_q;
  assign sel_ok        = (32'(road_sel) < NUM_ROADS);
  assign is_green_sel  = (road_sel == cur_q);
  assign green         = green_q;
  assign remainingTime = rem_q;
  assign overflow      = overflow_q;
  assign numOfCars     = cnt;

  for (genvar r = 0; r < NUM_ROADS; r++) begin : g_road
    plate_fifo #(.PLATE_W(PLATE_W), .QUEUE_DEPTH(QUEUE_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_v[r]),
      .pop       (pop_v[r]),
      .din       (plateIn),
      .dout      (head[r]),
      .full      (full_v[r]),
      .empty     (empty_v[r]),
      .count     (cnt[r]),
      .count_nxt (cnt_nxt[r])
    );
  end

  // Event decode; legality of a remove is judged against the pre-edge green.
  always_comb begin
    push_v     = '0;
    pop_v      = '0;
    overflow_d = 1'b0;
`ifdef BLACKLIST_EN
    bl_push    = 1'b0;
`endif
    if (ev && sel_ok) begin
      case (op_i)
        OP_ADD: begin
          push_v[road_sel] = 1'b1;
          overflow_d       = full_v[road_sel];
        end
        OP_REM: begin
          if (!empty_v[road_sel]) begin
            if (is_green_sel) pop_v[road_sel] = 1'b1;
`ifdef BLACKLIST_EN
            else begin
              pop_v[road_sel] = 1'b1;
              bl_push         = 1'b1;
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // Timer and round-robin; the leaving road adapts on its post-edge occupancy.
  always_comb begin
    cur_d   = cur_q;
    green_d = green_q;
    rem_d   = rem_q - 1'b1;
    gtime_d = gtime_q;
    cnt_lv  = cnt_nxt[cur_q];
    nxt     = (cur_q == RW'(NUM_ROADS - 1)) ? '0 : cur_q + 1'b1;
    if (rem_q == 7'd1) begin
      if (32'(cnt_lv) >= HI_THRESH)
        gtime_d[cur_q] = clamp_green(32'(gtime_q[cur_q]) + GREEN_STEP, GREEN_MIN, GREEN_MAX);
      else if (32'(cnt_lv) <= LO_THRESH)
        gtime_d[cur_q] = clamp_green(32'(gtime_q[cur_q]) - GREEN_STEP, GREEN_MIN, GREEN_MAX);
      cur_d   = nxt;
      green_d = NUM_ROADS'(1) << nxt;
      rem_d   = gtime_q[nxt];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      action_q   <= 1'b0;
      cur_q      <= '0;
      green_q    <= NUM_ROADS'(1);
      rem_q      <= 7'(GREEN_INIT);
      gtime_q    <= '{default: 7'(GREEN_INIT)};
      overflow_q <= 1'b0;
    end else begin
      action_q   <= action;
      cur_q      <= cur_d;
      green_q    <= green_d;
      rem_q      <= rem_d;
      gtime_q    <= gtime_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef BLACKLIST_EN
  localparam int BW = $clog2(BL_DEPTH + 1);
  localparam int IW = $clog2(BL_DEPTH);

  logic [PLATE_W-1:0] bl_mem_q [BL_DEPTH];
  logic [PLATE_W-1:0] bl_mem_d [BL_DEPTH];
  logic [BW-1:0]      bl_cnt_q, bl_cnt_d;
  logic [IW-1:0]      disp_idx_q, disp_idx_d;
  logic [PLATE_W-1:0] disp_q, disp_d;

  // Append when room remains (the plate is popped regardless); the viewer
  // walks valid entries while op is display and restarts at 0 afterwards.
  always_comb begin
    bl_mem_d   = bl_mem_q;
    bl_cnt_d   = bl_cnt_q;
    disp_idx_d = disp_idx_q;
    disp_d     = disp_q;
    if (bl_push && (bl_cnt_q < BW'(BL_DEPTH))) begin
      bl_mem_d[bl_cnt_q[IW-1:0]] = head[road_sel];
      bl_cnt_d                   = bl_cnt_q + 1'b1;
    end
    if (op_i == OP_DISP) begin
      if (bl_cnt_q == '0) begin
        disp_d = '0;
      end else begin
        disp_d     = bl_mem_q[disp_idx_q];
        disp_idx_d = (32'(disp_idx_q) + 1 >= 32'(bl_cnt_q)) ? '0 : disp_idx_q + 1'b1;
      end
    end else begin
      disp_idx_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bl_mem_q   <= '{default: '0};
      bl_cnt_q   <= '0;
      disp_idx_q <= '0;
      disp_q     <= '0;
    end else begin
      bl_mem_q   <= bl_mem_d;
      bl_cnt_q   <= bl_cnt_d;
      disp_idx_q <= disp_idx_d;
      disp_q     <= disp_d;
    end
  end

  assign blackListDisplay = disp_q;
`else
  // Queue contents have no consumer without the blacklist.
  logic unused_heads;
  assign unused_heads     = ^head;
  assign blackListDisplay = '0;
`endif

endmodule
